// File: rtl/bnn_pkg.sv
// Shared definitions for the binary neural-network layer blocks.
//   state_e           : sequencer state encoding (IDLE, EVAL, HOLD)
//   N_IN_DEFAULT      : default activation/weight vector width
//   N_NEURONS_DEFAULT : default neuron count per layer
package bnn_pkg;

  localparam int N_IN_DEFAULT      = 8;
  localparam int N_NEURONS_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/bnn_popcount.sv
// Combinational population count of a binary vector.
//   vec : input vector, N_IN bits
//   cnt : number of set bits, CNT_W bits unsigned (0..N_IN)
module bnn_popcount #(
  parameter int N_IN  = 8,
  parameter int CNT_W = $clog2(N_IN + 1)
) (
  input  logic [N_IN-1:0]  vec,
  output logic [CNT_W-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N_IN; i++) begin
      cnt = cnt + CNT_W'(vec[i]);
    end
  end

endmodule

// File: rtl/bnn_neuron_seq.sv
// Time-multiplexed XNOR-popcount-threshold sequencer for one BNN layer.
// Holds per-neuron weights/thresholds, accepts an activation vector, evaluates
// one neuron per cycle through a single shared datapath and then holds the
// layer output until downstream takes it.
//   clk, rst_n                      : clock, synchronous active-low reset
//   cfg_we/cfg_sel/cfg_addr/cfg_data : weight (sel=0) / threshold (sel=1) write
//   in_valid/in_ready/in_act        : activation vector handshake
//   out_valid/out_ready/out_y       : layer output handshake, bit i = neuron i
//   busy                            : high while evaluating or holding
module bnn_neuron_seq
  import bnn_pkg::*;
#(
  parameter int N_IN      = N_IN_DEFAULT,
  parameter int N_NEURONS = N_NEURONS_DEFAULT,
  parameter int CNT_W     = $clog2(N_IN + 1),
  parameter int IDX_W     = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic                 cfg_sel,
  input  logic [IDX_W-1:0]     cfg_addr,
  input  logic [N_IN-1:0]      cfg_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN-1:0]      in_act,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_NEURONS-1:0] out_y,
  output logic                 busy
);

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [N_IN-1:0]                 act_q, act_d;
  logic [N_NEURONS-1:0]            y_q, y_d;
  logic [N_NEURONS-1:0][N_IN-1:0]  w_q, w_d;
  logic [N_NEURONS-1:0][CNT_W-1:0] thr_q, thr_d;

  logic [N_IN-1:0]  match;
  logic [CNT_W-1:0] pop_cnt;
  logic             hit;
  logic             addr_ok;

  // Only non-power-of-two neuron counts can see an out-of-range address.
  if ((2 ** IDX_W) > N_NEURONS) begin : g_addr_chk
    assign addr_ok = (cfg_addr < IDX_W'(N_NEURONS));
  end else begin : g_addr_all
    assign addr_ok = 1'b1;
  end

  // Shared datapath: XNOR marks agreeing bits, popcount, threshold compare.
  assign match = ~(act_q ^ w_q[idx_q]);

  bnn_popcount #(
    .N_IN  (N_IN),
    .CNT_W (CNT_W)
  ) u_popcount (
    .vec (match),
    .cnt (pop_cnt)
  );

  assign hit = (pop_cnt >= thr_q[idx_q]);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_y     = y_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    act_d   = act_q;
    y_d     = y_q;
    w_d     = w_q;
    thr_d   = thr_q;
    unique case (state_q)
      IDLE: begin
        // Config lands at the same edge as an accept, so the vector being
        // accepted already evaluates against the new value.
        if (cfg_we && addr_ok) begin
          if (cfg_sel) thr_d[cfg_addr] = cfg_data[CNT_W-1:0];
          else         w_d[cfg_addr]   = cfg_data;
        end
        if (in_valid) begin
          act_d   = in_act;
          idx_d   = '0;
          state_d = EVAL;
        end
      end
      EVAL: begin
        // Bits not yet reached keep the previous layer result.
        y_d[idx_q] = hit;
        if (idx_q == IDX_W'(N_NEURONS - 1)) state_d = HOLD;
        else                                idx_d   = idx_q + IDX_W'(1);
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      act_q   <= '0;
      y_q     <= '0;
      w_q     <= '0;
      thr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      act_q   <= act_d;
      y_q     <= y_d;
      w_q     <= w_d;
      thr_q   <= thr_d;
    end
  end

endmodule
